dmem_ctrl: RTL

Parametrised, byte-banked data memory with a valid/ready request port, registered responses, sub-word loads/stores and misaligned-access handling. It sits in the processor's memory stage and replaces the single-cycle combinational-read data memory so the core can tolerate latency and report faults. Storage is four byte banks of DEPTH entries each. One request is accepted per cycle, except while a split access is in progress.

---
 rtl/dmem_ctrl.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/dmem_ctrl.sv
// Byte-banked data memory with a valid/ready request port, registered responses and sub-word access.
// Define DMEM_MISALIGN_SPLIT_EN to build two-cycle split handling of word-crossing accesses; otherwise misaligned H/W fault.
module dmem_ctrl #(
    parameter int DEPTH = 64,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_funct3,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_fault
);

    logic [7:0]    mem_q [4][DEPTH];
    logic          resp_valid_q, resp_valid_d;
    logic          resp_fault_q, resp_fault_d;
    logic [31:0]   resp_rdata_q, resp_rdata_d;

    logic          in_split;
    logic [1:0]    cur_off;
    logic [AW-1:0] cur_idx;
    logic          cur_we;
    logic [2:0]    cur_f3;
    logic [31:0]   cur_wdata;
    logic [2:0]    cur_sz;
    logic [1:0]    lane_pos [4];
    logic [3:0]    lane_act, lane_hi, lane_wen;
    logic [AW-1:0] lane_idx [4];
    logic [7:0]    lane_rd [4];
    logic [7:0]    lane_val [4];
    logic [7:0]    lane_wb [4];
    logic [31:0]   asm_data, ext_data;
    logic          legal, fire, access;
    logic          unused_addr;

    assign unused_addr = ^req_addr[31:AW+2];
    assign req_ready   = !reset && !in_split;
    assign fire        = req_valid && req_ready;

`ifdef DMEM_MISALIGN_SPLIT_EN
    typedef enum logic {IDLE = 1'b0, SPLIT = 1'b1} state_e;
    state_e        state_q, state_d;
    logic [AW+1:0] sv_addr_q, sv_addr_d;
    logic          sv_we_q, sv_we_d;
    logic [2:0]    sv_f3_q, sv_f3_d;
    logic [31:0]   sv_wdata_q, sv_wdata_d;
    logic [7:0]    lbuf_q [4];
    logic [7:0]    lbuf_d [4];
    logic          cross;

    assign in_split = (state_q == SPLIT);

    // During SPLIT the request port is stalled, so the access is driven from the saved copy.
    always_comb begin
        cur_off   = in_split ? sv_addr_q[1:0] : req_addr[1:0];
        cur_idx   = in_split ? sv_addr_q[AW+1:2] : req_addr[AW+1:2];
        cur_we    = in_split ? sv_we_q : req_we;
        cur_f3    = in_split ? sv_f3_q : req_funct3;
        cur_wdata = in_split ? sv_wdata_q : req_wdata;
    end
`else
    assign in_split = 1'b0;

    always_comb begin
        cur_off   = req_addr[1:0];
        cur_idx   = req_addr[AW+1:2];
        cur_we    = req_we;
        cur_f3    = req_funct3;
        cur_wdata = req_wdata;
    end
`endif

    // Lane k holds byte (k - offset) of the access; lanes below the offset live in the next word.
    always_comb begin
        case (cur_f3[1:0])
            2'b00:   cur_sz = 3'd1;
            2'b01:   cur_sz = 3'd2;
            default: cur_sz = 3'd4;
        endcase
        for (int k = 0; k < 4; k++) begin
            lane_pos[k] = 2'(k) - cur_off;
            lane_hi[k]  = 2'(k) < cur_off;
            lane_act[k] = {1'b0, lane_pos[k]} < cur_sz;
            lane_idx[k] = lane_hi[k] ? cur_idx + {{(AW-1){1'b0}}, 1'b1} : cur_idx;
            lane_rd[k]  = mem_q[k][lane_idx[k]];
            lane_wb[k]  = cur_wdata[{lane_pos[k], 3'b000} +: 8];
`ifdef DMEM_MISALIGN_SPLIT_EN
            lane_val[k] = (in_split && !lane_hi[k]) ? lbuf_q[k] : lane_rd[k];
`else
            lane_val[k] = lane_rd[k];
`endif
        end
        for (int i = 0; i < 4; i++) begin
            asm_data[8*i +: 8] = lane_val[2'(i) + cur_off];
        end
        case (cur_f3)
            3'b000:  ext_data = {{24{asm_data[7]}}, asm_data[7:0]};
            3'b001:  ext_data = {{16{asm_data[15]}}, asm_data[15:0]};
            3'b100:  ext_data = {24'h0, asm_data[7:0]};
            3'b101:  ext_data = {16'h0, asm_data[15:0]};
            default: ext_data = asm_data;
        endcase
        if (cur_we) legal = (cur_f3 == 3'b000) || (cur_f3 == 3'b001) || (cur_f3 == 3'b010);
        else        legal = (cur_f3 != 3'b011) && (cur_f3 != 3'b110) && (cur_f3 != 3'b111);
    end

    always_comb begin
        resp_valid_d = 1'b0;
        resp_fault_d = 1'b0;
        resp_rdata_d = '0;
        access       = 1'b0;
`ifdef DMEM_MISALIGN_SPLIT_EN
        cross      = ({1'b0, cur_off} + cur_sz) > 3'd4;
        state_d    = state_q;
        sv_addr_d  = sv_addr_q;
        sv_we_d    = sv_we_q;
        sv_f3_d    = sv_f3_q;
        sv_wdata_d = sv_wdata_q;
        lbuf_d     = lbuf_q;
        case (state_q)
            IDLE: begin
                if (fire) begin
                    if (!legal) begin
                        resp_valid_d = 1'b1;
                        resp_fault_d = 1'b1;
                    end else if (cross) begin
                        access     = 1'b1;
                        state_d    = SPLIT;
                        sv_addr_d  = req_addr[AW+1:0];
                        sv_we_d    = req_we;
                        sv_f3_d    = req_funct3;
                        sv_wdata_d = req_wdata;
                        lbuf_d     = lane_rd;
                    end else begin
                        access       = 1'b1;
                        resp_valid_d = 1'b1;
                        resp_rdata_d = cur_we ? '0 : ext_data;
                    end
                end
            end
            SPLIT: begin
                access       = 1'b1;
                resp_valid_d = 1'b1;
                resp_rdata_d = cur_we ? '0 : ext_data;
                state_d      = IDLE;
            end
        endcase
`else
        if (fire) begin
            resp_valid_d = 1'b1;
            if (!legal || (cur_f3[1:0] == 2'b01 && cur_off[0]) || (cur_f3[1:0] == 2'b10 && cur_off != 2'b00)) begin
                resp_fault_d = 1'b1;
            end else begin
                access       = 1'b1;
                resp_rdata_d = cur_we ? '0 : ext_data;
            end
        end
`endif
    end

    // The low lanes are written on the accept edge, the wrapped high lanes on the SPLIT edge.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            lane_wen[k] = access && cur_we && lane_act[k] && (lane_hi[k] == in_split);
        end
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (lane_wen[k]) mem_q[k][lane_idx[k]] <= lane_wb[k];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            resp_valid_q <= 1'b0;
            resp_fault_q <= 1'b0;
            resp_rdata_q <= '0;
        end else begin
            resp_valid_q <= resp_valid_d;
            resp_fault_q <= resp_fault_d;
            resp_rdata_q <= resp_rdata_d;
        end
    end

`ifdef DMEM_MISALIGN_SPLIT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            sv_addr_q  <= '0;
            sv_we_q    <= 1'b0;
            sv_f3_q    <= '0;
            sv_wdata_q <= '0;
            for (int k = 0; k < 4; k++) lbuf_q[k] <= '0;
        end else begin
            state_q    <= state_d;
            sv_addr_q  <= sv_addr_d;
            sv_we_q    <= sv_we_d;
            sv_f3_q    <= sv_f3_d;
            sv_wdata_q <= sv_wdata_d;
            lbuf_q     <= lbuf_d;
        end
    end
`endif

    assign resp_valid = resp_valid_q;
    assign resp_fault = resp_fault_q;
    assign resp_rdata = resp_rdata_q;

endmodule
